mcpu6bit_memio: RTL and testbench



---
 rtl/mcpu6bit_memio_if.sv | 23 ++
 rtl/mcpu6bit_memio.sv | 65 ++++++
 tb/tb_mcpu6bit_memio.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mcpu6bit_memio_if.sv
// mcpu6bit_memio_if: CPU bus, loader stream and IO port signals of the memory/loader block.
interface mcpu6bit_memio_if;
    logic [5:0] cpu_bus;
    logic       cpu_we;
    logic [5:0] cpu_datain;
    logic       cpu_rst_n;
    logic       ld_start;
    logic       go;
    logic       ld_valid;
    logic [5:0] ld_data;
    logic       ld_ready;
    logic       ld_done;
    logic [5:0] io_out;
    logic       io_strobe;
    modport master (
        output cpu_bus, cpu_we, ld_start, go, ld_valid, ld_data,
        input  cpu_datain, cpu_rst_n, ld_ready, ld_done, io_out, io_strobe
    );
    modport slave (
        input  cpu_bus, cpu_we, ld_start, go, ld_valid, ld_data,
        output cpu_datain, cpu_rst_n, ld_ready, ld_done, io_out, io_strobe
    );
endinterface

// File: rtl/mcpu6bit_memio.sv
// mcpu6bit_memio: 16x6 program/data memory with streaming loader and memory-mapped output port.
module mcpu6bit_memio #(
    parameter logic [3:0] IO_ADDR = 4'hF
) (
    input logic             clk,
    input logic             rst,
    mcpu6bit_memio_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2, RUN = 2'd3;
    logic [1:0] state, nxt;
    logic [3:0] ptr, addr_q;
    logic [5:0] mem [16];
    logic       rst_n_q, ld_wr, cpu_wr, io_wr;
    assign ld_wr  = state == LOAD && bus.ld_valid;
    assign cpu_wr = state == RUN && !bus.cpu_we;
    assign io_wr  = cpu_wr && addr_q == IO_ADDR;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.ld_start ? LOAD : bus.go ? RUN : IDLE;
            LOAD:    nxt = ld_wr && ptr == 4'hF ? DONE : LOAD;
            DONE:    nxt = RUN;
            default: nxt = bus.ld_start ? LOAD : RUN;
        endcase
    end
    // cpu_rst_n stays low for the first RUN cycle so the CPU sees a reset edge after every load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            rst_n_q <= 1'b0;
        end else begin
            state   <= nxt;
            ptr     <= nxt == LOAD && state != LOAD ? 4'd0 : ld_wr ? ptr + 4'd1 : ptr;
            rst_n_q <= state == RUN && nxt == RUN;
        end
    end
    // address phase ends on the falling edge of clk
    always_ff @(negedge clk or posedge rst) begin
        if (rst) addr_q <= '0;
        else     addr_q <= bus.cpu_bus[3:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (ld_wr) begin
            mem[ptr] <= bus.ld_data;
        end else if (cpu_wr) begin
            mem[addr_q] <= bus.cpu_bus;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.io_out    <= '0;
            bus.io_strobe <= 1'b0;
        end else begin
            bus.io_strobe <= io_wr;
            if (io_wr) bus.io_out <= bus.cpu_bus;
        end
    end
    assign bus.cpu_datain = mem[addr_q];
    assign bus.cpu_rst_n  = rst_n_q;
    assign bus.ld_ready   = state == LOAD;
    assign bus.ld_done    = state == DONE;
endmodule

// File: tb/tb_mcpu6bit_memio.sv
// tb_mcpu6bit_memio: directed checks of reset, loader, write gating and a small attached CPU model.
module tb_mcpu6bit_memio;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [5:0] img [16];
    logic [3:0] pc, ir_addr, last_fetch;
    logic [1:0] ir_op;
    logic [5:0] acc;
    logic       cy, ex;
    int         strobes;
    mcpu6bit_memio_if bus_if();
    mcpu6bit_memio #(.IO_ADDR(4'hF)) dut (.clk(clk), .rst(rst), .bus(bus_if));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic rd(input logic [3:0] a, input logic [5:0] exp);
        bus_if.cpu_bus = {2'b00, a};
        @(negedge clk);
        #1;
        chk($sformatf("rd%0d", a), {2'b00, bus_if.cpu_datain}, {2'b00, exp});
    endtask
    // back-to-back when gap=0, otherwise gap idle cycles before each word
    task automatic load(input int gap);
        bus_if.cpu_we = 1'b1;
        bus_if.ld_start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.ld_start = 1'b0;
        chk("load_ready", {7'd0, bus_if.ld_ready}, 8'd1);
        chk("load_rst_n", {7'd0, bus_if.cpu_rst_n}, 8'd0);
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            bus_if.ld_valid = 1'b1;
            bus_if.ld_data = img[i];
            @(posedge clk);
            #1;
            bus_if.ld_valid = 1'b0;
            chk("ld_done", {7'd0, bus_if.ld_done}, {7'd0, i == 15});
        end
        chk("done_ready", {7'd0, bus_if.ld_ready}, 8'd0);
        @(posedge clk);
        #1;
        chk("done_pulse", {7'd0, bus_if.ld_done}, 8'd0);
        chk("run1_rst_n", {7'd0, bus_if.cpu_rst_n}, 8'd0);
        @(posedge clk);
        #1;
        chk("run2_rst_n", {7'd0, bus_if.cpu_rst_n}, 8'd1);
    endtask
    // fetch/execute CPU: op 0 NOR, 1 ADD, 2 STA, 3 JCC; address phase while clk high
    task automatic cpu_run(input int n);
        logic [5:0] din;
        logic [6:0] sum;
        logic       rn;
        pc = 0; acc = 0; cy = 0; ex = 0; strobes = 0; last_fetch = 4'hx;
        ir_op = 0; ir_addr = 0;
        bus_if.cpu_bus = 6'd0;
        bus_if.cpu_we = 1'b1;
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            #1;
            bus_if.cpu_bus = acc;
            din = bus_if.cpu_datain;
            rn = bus_if.cpu_rst_n;
            if (bus_if.io_strobe) strobes++;
            @(posedge clk);
            #1;
            if (!rn) begin
                pc = 0; acc = 0; cy = 0; ex = 0;
            end else if (!ex) begin
                {ir_op, ir_addr} = din;
                last_fetch = pc;
                pc = pc + 4'd1;
                ex = 1'b1;
            end else begin
                if (ir_op == 2'd0) acc = ~(acc | din);
                if (ir_op == 2'd1) begin
                    sum = {1'b0, acc} + {1'b0, din};
                    {cy, acc} = sum;
                end
                if (ir_op == 2'd3) begin
                    if (!cy) pc = ir_addr;
                    else cy = 1'b0;
                end
                ex = 1'b0;
            end
            bus_if.cpu_bus = {2'b00, ex ? ir_addr : pc};
            bus_if.cpu_we = !(ex && ir_op == 2'd2);
        end
        bus_if.cpu_we = 1'b1;
    endtask
    initial begin
        bus_if.cpu_bus = 6'd0;
        bus_if.cpu_we = 1'b1;
        bus_if.ld_start = 1'b0;
        bus_if.go = 1'b0;
        bus_if.ld_valid = 1'b0;
        bus_if.ld_data = 6'd0;
        #2;
        chk("rst_rst_n", {7'd0, bus_if.cpu_rst_n}, 8'd0);
        chk("rst_ready", {7'd0, bus_if.ld_ready}, 8'd0);
        chk("rst_done", {7'd0, bus_if.ld_done}, 8'd0);
        chk("rst_io", {2'b00, bus_if.io_out}, 8'd0);
        chk("rst_strobe", {7'd0, bus_if.io_strobe}, 8'd0);
        chk("rst_datain", {2'b00, bus_if.cpu_datain}, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_rst_n", {7'd0, bus_if.cpu_rst_n}, 8'd0);
        chk("idle_ready", {7'd0, bus_if.ld_ready}, 8'd0);
        bus_if.cpu_we = 1'b0;
        bus_if.cpu_bus = 6'h15;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("strobe_idle", {7'd0, bus_if.io_strobe}, 8'd0);
        end
        chk("mem5_idle", {2'b00, bus_if.cpu_datain}, 8'd0);
        bus_if.ld_start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.ld_start = 1'b0;
        chk("partial_ready", {7'd0, bus_if.ld_ready}, 8'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("strobe_load", {7'd0, bus_if.io_strobe}, 8'd0);
        end
        chk("mem5_load_idle", {2'b00, bus_if.cpu_datain}, 8'd0);
        for (int i = 0; i < 7; i++) begin
            bus_if.ld_valid = 1'b1;
            bus_if.ld_data = 6'h21 + 6'(i);
            @(posedge clk);
            #1;
            bus_if.ld_valid = 1'b0;
        end
        chk("mem5_loaded", {2'b00, bus_if.cpu_datain}, 8'h26);
        chk("io_blocked", {2'b00, bus_if.io_out}, 8'd0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ready", {7'd0, bus_if.ld_ready}, 8'd0);
        chk("arst_rst_n", {7'd0, bus_if.cpu_rst_n}, 8'd0);
        chk("arst_datain", {2'b00, bus_if.cpu_datain}, 8'd0);
        #3;
        rst = 1'b0;
        bus_if.cpu_we = 1'b1;
        for (int a = 0; a < 16; a++) rd(4'(a), 6'd0);
        bus_if.go = 1'b1;
        @(posedge clk);
        #1;
        bus_if.go = 1'b0;
        chk("go1_rst_n", {7'd0, bus_if.cpu_rst_n}, 8'd0);
        @(posedge clk);
        #1;
        chk("go2_rst_n", {7'd0, bus_if.cpu_rst_n}, 8'd1);
        for (int i = 0; i < 16; i++) img[i] = 6'd0;
        img[0] = 6'h0E; img[1] = 6'h2F; img[2] = 6'h32;
        load(0);
        cpu_run(30);
        chk("prog1_io", {2'b00, bus_if.io_out}, 8'h3F);
        chk("prog1_strobes", 8'(strobes), 8'd1);
        chk("prog1_loop", {4'd0, last_fetch}, 8'd2);
        for (int i = 0; i < 16; i++) img[i] = 6'd0;
        img[0] = 6'h0E; img[1] = 6'h1D; img[2] = 6'h2F; img[3] = 6'h33; img[4] = 6'h34; img[13] = 6'h02;
        load(0);
        chk("io_keep", {2'b00, bus_if.io_out}, 8'h3F);
        cpu_run(40);
        chk("prog2_io", {2'b00, bus_if.io_out}, 8'h01);
        chk("prog2_strobes", 8'(strobes), 8'd1);
        chk("prog2_loop", {4'd0, last_fetch}, 8'd4);
        for (int i = 0; i < 16; i++) img[i] = 6'(i * 5 + 3);
        load(2);
        for (int a = 0; a < 16; a++) rd(4'(a), 6'(a * 5 + 3));
        chk("run_rst_n", {7'd0, bus_if.cpu_rst_n}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arun_rst_n", {7'd0, bus_if.cpu_rst_n}, 8'd0);
        chk("arun_io", {2'b00, bus_if.io_out}, 8'd0);
        chk("arun_datain", {2'b00, bus_if.cpu_datain}, 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
